// File: rtl/counter_sweep_ctrl.sv
// Triangle-sweep sequencer for the 8-bit loadable up/down counter.
// Loads a start value, counts up to hi_lim, down to lo_lim, and repeats
// for the requested number of sweeps. Counter control pins are decoded
// from the current state so the counter acts on the same edge as the FSM.
//
//  state  | meaning
//  -------+--------------------------------------------------------------
//  IDLE   | waiting for start; counter held at its current value
//  LOAD   | counter loads the latched start value
//  UP     | counter increments until it reaches hi_lim
//  DOWN   | counter decrements until it reaches lo_lim (one sweep done)
//  DONE   | all sweeps complete; counter held, done pulse follows
module counter_sweep_ctrl #(
   parameter int DATA_WIDTH  = 8,
   parameter int SWEEP_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   clear,
   input  logic                   start,
   input  logic                   abort,
   input  logic [DATA_WIDTH-1:0]  start_val,
   input  logic [DATA_WIDTH-1:0]  hi_lim,
   input  logic [DATA_WIDTH-1:0]  lo_lim,
   input  logic [SWEEP_WIDTH-1:0] sweeps,
   input  logic [DATA_WIDTH-1:0]  cnt_qd,
   output logic [DATA_WIDTH-1:0]  cnt_d,
   output logic                   cnt_load,
   output logic                   cnt_up_down,
   output logic                   cnt_clear_n,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [SWEEP_WIDTH-1:0] sweep_cnt
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_UP   = 3'd2,
      S_DOWN = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam int EW = DATA_WIDTH + 1;

   state_t                 state_q, state_d;
   logic [DATA_WIDTH-1:0]  start_val_q, start_val_d;
   logic [DATA_WIDTH-1:0]  hi_lim_q, hi_lim_d;
   logic [DATA_WIDTH-1:0]  lo_lim_q, lo_lim_d;
   logic [SWEEP_WIDTH-1:0] sweeps_q, sweeps_d;
   logic [SWEEP_WIDTH-1:0] sweep_cnt_q, sweep_cnt_d;
   logic                   err_q, err_d;
   logic                   done_q;

   logic [EW-1:0]          qd_inc, qd_dec;
   logic                   params_ok;

   // Turn-point detection looks one step ahead; the extra bit keeps the
   // +/-1 from aliasing at the ends of the range.
   assign qd_inc = {1'b0, cnt_qd} + EW'(1);
   assign qd_dec = {1'b0, cnt_qd} - EW'(1);

   assign params_ok = (lo_lim < hi_lim) && (lo_lim <= start_val) &&
                      (start_val <= hi_lim) && (sweeps != '0);

   // Next-state, parameter latching and counter pin decode.
   always_comb begin
      state_d     = state_q;
      start_val_d = start_val_q;
      hi_lim_d    = hi_lim_q;
      lo_lim_d    = lo_lim_q;
      sweeps_d    = sweeps_q;
      sweep_cnt_d = sweep_cnt_q;
      err_d       = 1'b0;
      cnt_load    = 1'b0;
      cnt_d       = cnt_qd;
      cnt_up_down = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_load = 1'b1;
            if (start) begin
               if (params_ok) begin
                  start_val_d = start_val;
                  hi_lim_d    = hi_lim;
                  lo_lim_d    = lo_lim;
                  sweeps_d    = sweeps;
                  sweep_cnt_d = '0;
                  state_d     = S_LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_LOAD: begin
            cnt_load = 1'b1;
            cnt_d    = start_val_q;
            if (abort)
               state_d = S_IDLE;
            else if (start_val_q < hi_lim_q)
               state_d = S_UP;
            else
               state_d = S_DOWN;
         end
         S_UP: begin
            cnt_up_down = 1'b1;
            if (abort)
               state_d = S_IDLE;
            else if (qd_inc == {1'b0, hi_lim_q})
               state_d = S_DOWN;
         end
         S_DOWN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (qd_dec == {1'b0, lo_lim_q}) begin
               sweep_cnt_d = sweep_cnt_q + SWEEP_WIDTH'(1);
               state_d     = (sweep_cnt_d == sweeps_q) ? S_DONE : S_UP;
            end
         end
         S_DONE: begin
            cnt_load = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and latched-parameter registers with synchronous clear.
   always_ff @(posedge clk) begin
      if (clear) begin
         state_q     <= S_IDLE;
         start_val_q <= '0;
         hi_lim_q    <= '0;
         lo_lim_q    <= '0;
         sweeps_q    <= '0;
         sweep_cnt_q <= '0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         start_val_q <= start_val_d;
         hi_lim_q    <= hi_lim_d;
         lo_lim_q    <= lo_lim_d;
         sweeps_q    <= sweeps_d;
         sweep_cnt_q <= sweep_cnt_d;
         err_q       <= err_d;
         done_q      <= (state_q == S_DONE);
      end
   end

   assign cnt_clear_n = ~clear;
   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign err         = err_q;
   assign sweep_cnt   = sweep_cnt_q;

endmodule
